// File: rtl/mac_tree_stage.sv
// Three-stage multiply / adder-tree stage feeding the accumulator.
// S1 holds the masked lane products, S2 the pair sums and S3 the final sum. All stages advance together on one global enable.
module mac_tree_stage #(
  parameter int DW    = 16,
  parameter int OW    = 32,
  parameter int LANES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*DW-1:0]   in_a,
  input  logic [LANES*DW-1:0]   in_b,
  input  logic [LANES-1:0]      in_mask,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OW-1:0]         out_sum,
  output logic                  out_last,
  output logic [7:0]            out_beats
);

  logic                 s1_v_q, s1_v_d;
  logic [OW-1:0]        s1_p_q [LANES];
  logic [OW-1:0]        s1_p_d [LANES];
  logic                 s1_last_q, s1_last_d;

  logic                 s2_v_q, s2_v_d;
  logic [OW-1:0]        s2_lo_q, s2_lo_d;
  logic [OW-1:0]        s2_hi_q, s2_hi_d;
  logic                 s2_last_q, s2_last_d;

  logic                 s3_v_q, s3_v_d;
  logic [OW-1:0]        s3_sum_q, s3_sum_d;
  logic                 s3_last_q, s3_last_d;

  logic [7:0]           cnt_q, cnt_d;

  logic signed [2*DW-1:0] prod [LANES];
  logic                   stall;

  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      prod[i] = '0;
      if (in_mask[i]) begin
        prod[i] = $signed(in_a[i*DW +: DW]) * $signed(in_b[i*DW +: DW]);
      end
    end
  end

  always_comb begin
    stall     = s3_v_q && !out_ready;

    s1_v_d    = s1_v_q;
    s1_p_d    = s1_p_q;
    s1_last_d = s1_last_q;
    s2_v_d    = s2_v_q;
    s2_lo_d   = s2_lo_q;
    s2_hi_d   = s2_hi_q;
    s2_last_d = s2_last_q;
    s3_v_d    = s3_v_q;
    s3_sum_d  = s3_sum_q;
    s3_last_d = s3_last_q;

    if (flush) begin
      // Drop only the valid bits; data keeps its last loaded value.
      s1_v_d = 1'b0;
      s2_v_d = 1'b0;
      s3_v_d = 1'b0;
    end else if (!stall) begin
      s1_v_d = in_valid;
      if (in_valid) begin
        for (int unsigned i = 0; i < LANES; i++) begin
          s1_p_d[i] = OW'(prod[i]);
        end
        s1_last_d = in_last;
      end
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        s2_lo_d   = s1_p_q[0] + s1_p_q[1];
        s2_hi_d   = s1_p_q[2] + s1_p_q[3];
        s2_last_d = s1_last_q;
      end
      s3_v_d = s2_v_q;
      if (s2_v_q) begin
        s3_sum_d  = s2_lo_q + s2_hi_q;
        s3_last_d = s2_last_q;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else if (s3_v_q && out_ready) begin
      if (s3_last_q) begin
        cnt_d = '0;
      end else if (cnt_q != 8'hFF) begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q    <= 1'b0;
      s1_last_q <= 1'b0;
      for (int unsigned i = 0; i < LANES; i++) begin
        s1_p_q[i] <= '0;
      end
      s2_v_q    <= 1'b0;
      s2_lo_q   <= '0;
      s2_hi_q   <= '0;
      s2_last_q <= 1'b0;
      s3_v_q    <= 1'b0;
      s3_sum_q  <= '0;
      s3_last_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_p_q    <= s1_p_d;
      s1_last_q <= s1_last_d;
      s2_v_q    <= s2_v_d;
      s2_lo_q   <= s2_lo_d;
      s2_hi_q   <= s2_hi_d;
      s2_last_q <= s2_last_d;
      s3_v_q    <= s3_v_d;
      s3_sum_q  <= s3_sum_d;
      s3_last_q <= s3_last_d;
      cnt_q     <= cnt_d;
    end
  end

  assign in_ready  = !stall;
  assign out_valid = s3_v_q;
  assign out_sum   = s3_sum_q;
  assign out_last  = s3_last_q;
  // The counter is the number of beats already delivered, so this beat is one more, clamped at 255.
  assign out_beats = !s3_v_q ? 8'd0 : (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;

endmodule

// File: tb/tb_mac_tree_stage.sv
// Bench for mac_tree_stage: a table of single beats checked at exact latency, hand sequences for stall/flush/reset,
// and random traffic checked against a queue-based reference model.
module tb_mac_tree_stage;
  localparam int DW = 16;
  localparam int OW = 32;
  localparam int LANES = 4;

  logic clk = 1'b0;
  logic rst_n, flush, in_valid, in_ready, in_last, out_valid, out_ready, out_last;
  logic [LANES*DW-1:0] in_a, in_b;
  logic [LANES-1:0]    in_mask;
  logic [OW-1:0]       out_sum;
  logic [7:0]          out_beats;

  mac_tree_stage #(.DW(DW), .OW(OW), .LANES(LANES)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mask(in_mask), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_last(out_last), .out_beats(out_beats)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  mask;
    logic        last;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] sum;
    logic        last;
  } exp_t;

  int checks = 0;
  int errors = 0;
  exp_t q[$];
  int mcnt = 0;
  int nout = 0;
  int stall_cnt = 0;
  bit mon_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] pk(input int l0, input int l1, input int l2, input int l3);
    return {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
  endfunction

  // Reference: exact integer dot product over enabled lanes, then keep the low OW bits.
  function automatic logic [31:0] ref_sum(input logic [63:0] a, input logic [63:0] b, input logic [3:0] m);
    longint s = 0;
    logic signed [15:0] x, y;
    for (int i = 0; i < LANES; i++) begin
      x = a[16*i +: 16];
      y = b[16*i +: 16];
      if (m[i]) s += longint'(x) * longint'(y);
    end
    return s[31:0];
  endfunction

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      exp_t e;
      int eb;
      chk("in_ready", {63'd0, in_ready}, {63'd0, !(out_valid && !out_ready)});
      if (!in_ready) stall_cnt++;
      if (!out_valid) chk("beats_idle", {56'd0, out_beats}, 64'd0);
      if (flush) begin
        q.delete();
        mcnt = 0;
      end else begin
        if (out_valid && out_ready) begin
          nout++;
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out actual=%0h required=none", out_sum);
          end else begin
            e = q.pop_front();
            eb = (mcnt + 1 > 255) ? 255 : mcnt + 1;
            chk("out_sum", {32'd0, out_sum}, {32'd0, e.sum});
            chk("out_last", {63'd0, out_last}, {63'd0, e.last});
            chk("out_beats", {56'd0, out_beats}, 64'(eb));
            if (e.last) mcnt = 0;
            else if (mcnt < 255) mcnt++;
          end
        end
        if (in_valid && in_ready) begin
          e.sum = ref_sum(in_a, in_b, in_mask);
          e.last = in_last;
          q.push_back(e);
        end
      end
    end
  end

  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [3:0] m, input logic l);
    bit r = 0;
    in_a = a; in_b = b; in_mask = m; in_last = l; in_valid = 1'b1;
    for (int t = 0; t < 50 && !r; t++) begin
      @(negedge clk) r = in_ready;
      @(posedge clk) #1;
    end
    if (!r) chk("send_timeout", 64'(r), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic single(input vec_t v);
    out_ready = 1'b1;
    send(v.a, v.b, v.mask, v.last);
    chk("lat_s1", {63'd0, out_valid}, 64'd0);
    @(posedge clk) #1;
    chk("lat_s2", {63'd0, out_valid}, 64'd0);
    @(posedge clk) #1;
    chk("lat_s3", {63'd0, out_valid}, 64'd1);
    chk("tbl_sum", {32'd0, out_sum}, {32'd0, v.exp});
    chk("tbl_last", {63'd0, out_last}, {63'd0, v.last});
    chk("tbl_beats", {56'd0, out_beats}, 64'd1);
    @(posedge clk) #1;
  endtask

  task automatic drain();
    out_ready = 1'b1; in_valid = 1'b0; flush = 1'b0;
    for (int i = 0; i < 30 && (q.size() != 0 || out_valid); i++) @(posedge clk) #1;
    chk("drain", 64'(q.size()), 64'd0);
  endtask

  vec_t tbl[6];

  initial begin
    int n0;
    tbl[0] = '{pk(1, 2, 3, 4), pk(5, 6, 7, 8), 4'hF, 1'b1, 32'd70};
    tbl[1] = '{pk(-32768, -32768, -32768, -32768), pk(-32768, -32768, -32768, -32768), 4'hF, 1'b1, 32'h0000_0000};
    tbl[2] = '{pk(-3, 0, 0, 0), pk(5, 0, 0, 0), 4'hF, 1'b1, 32'hFFFF_FFF1};
    tbl[3] = '{pk(10, 20, 30, 40), pk(1, 1, 1, 1), 4'b0101, 1'b1, 32'd40};
    tbl[4] = '{pk(10, 20, 30, 40), pk(1, 1, 1, 1), 4'b0000, 1'b1, 32'd0};
    tbl[5] = '{pk(32767, 32767, 32767, 32767), pk(-32768, -32768, -32768, -32768), 4'hF, 1'b1, 32'h0002_0000};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_mask = '0; in_last = 1'b0;
    #12;
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_sum", {32'd0, out_sum}, 64'd0);
    chk("rst_last", {63'd0, out_last}, 64'd0);
    chk("rst_beats", {56'd0, out_beats}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    mon_en = 1;

    for (int i = 0; i < 6; i++) single(tbl[i]);

    // Six beats of ones with the accumulator stalling in cycles 4-6.
    stall_cnt = 0;
    n0 = nout;
    fork
      for (int k = 0; k < 6; k++) send(pk(1, 1, 1, 1), pk(1, 1, 1, 1), 4'hF, k == 5);
      for (int c = 0; c < 12; c++) begin
        out_ready = !(c >= 4 && c <= 6);
        @(posedge clk) #1;
      end
    join
    drain();
    chk("stall_cycles", 64'(stall_cnt), 64'd3);
    chk("stream_outs", 64'(nout - n0), 64'd6);

    // Leave the counter mid-group, stall three beats in flight, then flush.
    send(pk(1, 1, 1, 1), pk(2, 2, 2, 2), 4'hF, 1'b0);
    drain();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) send(pk(k, 1, 1, 1), pk(3, 3, 3, 3), 4'hF, 1'b0);
    chk("pre_flush_valid", {63'd0, out_valid}, 64'd1);
    flush = 1'b1;
    @(posedge clk) #1;
    flush = 1'b0;
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    out_ready = 1'b1;
    n0 = nout;
    repeat (5) @(posedge clk) #1;
    chk("flush_no_out", 64'(nout - n0), 64'd0);
    single(tbl[0]);

    // Asynchronous reset between edges while a beat is held on the output.
    out_ready = 1'b0;
    send(pk(7, 7, 7, 7), pk(7, 7, 7, 7), 4'hF, 1'b0);
    send(pk(2, 2, 2, 2), pk(7, 7, 7, 7), 4'hF, 1'b0);
    repeat (2) @(posedge clk) #1;
    chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
    #2;
    mon_en = 0;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_sum", {32'd0, out_sum}, 64'd0);
    chk("arst_last", {63'd0, out_last}, 64'd0);
    chk("arst_beats", {56'd0, out_beats}, 64'd0);
    @(posedge clk) #2;
    rst_n = 1'b1;
    q.delete();
    mcnt = 0;
    out_ready = 1'b1;
    @(posedge clk) #1;
    mon_en = 1;
    single(tbl[2]);

    // Group longer than 255 beats: out_beats must clamp.
    out_ready = 1'b1;
    for (int k = 0; k < 260; k++) send(64'($urandom) << 32 | 64'($urandom), 64'($urandom), 4'($urandom), 1'b0);
    send(pk(1, 1, 1, 1), pk(1, 1, 1, 1), 4'hF, 1'b1);
    drain();

    // Random traffic with backpressure and occasional flush.
    for (int c = 0; c < 600; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_a = {$urandom, $urandom};
      in_b = {$urandom, $urandom};
      in_mask = 4'($urandom);
      in_last = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 39) == 0);
      @(posedge clk) #1;
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
